// File: rtl/multirate_pkg.sv
// Shared defaults, FSM state type and a width helper for the decimating
// polyphase FIR branch sequencer.
package multirate_pkg;

    localparam int DIN_W_DEF  = 16;
    localparam int COEF_W_DEF = 9;
    localparam int PROD_W_DEF = DIN_W_DEF + COEF_W_DEF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/multirate_fir_mac_sched_if.sv
// Sample stream, output stream and coefficient-write port of one FIR branch.
interface multirate_fir_mac_sched_if #(
    parameter int DIN_W  = 16,
    parameter int COEF_W = 9,
    parameter int DOUT_W = 16,
    parameter int AW     = 4
);
    logic signed [DIN_W-1:0]  s_data;
    logic                     s_valid;
    logic                     s_ready;
    logic signed [DOUT_W-1:0] m_data;
    logic                     m_valid;
    logic                     m_ready;
    logic                     coef_we;
    logic [AW-1:0]            coef_addr;
    logic [COEF_W-1:0]        coef_data;
    logic                     coef_err;
    logic                     busy;

    modport slave (
        input  s_data, s_valid, m_ready, coef_we, coef_addr, coef_data,
        output s_ready, m_data, m_valid, coef_err, busy
    );

    modport master (
        output s_data, s_valid, m_ready, coef_we, coef_addr, coef_data,
        input  s_ready, m_data, m_valid, coef_err, busy
    );
endinterface

// File: rtl/multirate_mac_dp.sv
// Shared 16s x 9u multiplier, product register, accumulator and output scaling.
// MULTIRATE_OUT_SAT_EN selects clamping of the scaled result; otherwise it wraps.
module multirate_mac_dp
    import multirate_pkg::*;
#(
    parameter int DIN_W  = DIN_W_DEF,
    parameter int COEF_W = COEF_W_DEF,
    parameter int DOUT_W = 16,
    parameter int ACC_W  = PROD_W_DEF + 4,
    parameter int SHIFT  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     vld_p0,
    input  logic                     first_p0,
    input  logic signed [DIN_W-1:0]  x_p0,
    input  logic [COEF_W-1:0]        c_p0,
    output logic signed [DOUT_W-1:0] dout
);
    localparam int PROD_W = DIN_W + COEF_W;

    logic signed [PROD_W-1:0] prod_p1;
    logic                     vld_p1;
    logic                     first_p1;
    logic signed [ACC_W-1:0]  acc_p2;
    logic signed [ACC_W-1:0]  shifted;

`ifdef MULTIRATE_OUT_SAT_EN
    localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-DOUT_W+1){1'b0}}, {(DOUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OUT_MIN = {{(ACC_W-DOUT_W+1){1'b1}}, {(DOUT_W-1){1'b0}}};

    function automatic logic signed [DOUT_W-1:0] sat_or_wrap(input logic signed [ACC_W-1:0] v);
        if (v > OUT_MAX) return DOUT_W'(OUT_MAX);
        if (v < OUT_MIN) return DOUT_W'(OUT_MIN);
        return DOUT_W'(v);
    endfunction
`else
    function automatic logic signed [DOUT_W-1:0] sat_or_wrap(input logic signed [ACC_W-1:0] v);
        return DOUT_W'(v);
    endfunction
`endif

    // p0 -> p1: coefficient is zero-extended so the product stays signed
    // p1 -> p2: the first product of a pass reloads the accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_p1  <= '0;
            vld_p1   <= 1'b0;
            first_p1 <= 1'b0;
            acc_p2   <= '0;
        end else begin
            vld_p1   <= vld_p0;
            first_p1 <= first_p0;
            if (vld_p0) prod_p1 <= PROD_W'(x_p0) * PROD_W'($signed({1'b0, c_p0}));
            if (vld_p1) acc_p2 <= first_p1 ? ACC_W'(prod_p1) : acc_p2 + ACC_W'(prod_p1);
        end
    end

    assign shifted = acc_p2 >>> SHIFT;
    assign dout    = sat_or_wrap(shifted);

endmodule

// File: rtl/multirate_fir_mac_sched.sv
// Decimating polyphase FIR branch sequencer: delay line, coefficient RAM, FSM and
// handshakes around multirate_mac_dp. Output clamping via MULTIRATE_OUT_SAT_EN.
module multirate_fir_mac_sched
    import multirate_pkg::*;
#(
    parameter int NTAPS  = 16,
    parameter int DECIM  = 4,
    parameter int SHIFT  = 8,
    parameter int DIN_W  = DIN_W_DEF,
    parameter int COEF_W = COEF_W_DEF,
    parameter int DOUT_W = 16
) (
    input  logic                       ap_clk,
    input  logic                       ap_rst_n,
    multirate_fir_mac_sched_if.slave   io
);
    localparam int AW     = clog2(NTAPS);
    localparam int PROD_W = DIN_W + COEF_W;
    localparam int ACC_W  = PROD_W + AW;
    localparam logic [AW-1:0] PH_LAST  = AW'(DECIM - 1);
    localparam logic [AW-1:0] TAP_LAST = AW'(NTAPS - 1);

    state_t                   state, state_nxt;
    logic [AW-1:0]            wptr, phase, tap, raddr;
    logic signed [DIN_W-1:0]  dline [NTAPS];
    logic [COEF_W-1:0]        coef  [NTAPS];
    logic                     s_ready_q, m_valid_q, coef_err_q;
    logic signed [DOUT_W-1:0] m_data_q, dout;
    logic                     accept, out_done, vld_p0, first_p0;

    assign accept   = io.s_valid && s_ready_q;
    assign out_done = (state == OUT) && m_valid_q && io.m_ready;

    always_comb begin
        state_nxt = state;
        vld_p0    = 1'b0;
        first_p0  = 1'b0;
        raddr     = wptr - tap - AW'(1);
        unique case (state)
            IDLE:    if (accept && phase == PH_LAST) state_nxt = MAC;
            MAC: begin
                vld_p0   = 1'b1;
                first_p0 = (tap == '0);
                if (tap == TAP_LAST) state_nxt = DRAIN;
            end
            DRAIN:   state_nxt = OUT;
            OUT:     if (out_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // s_ready is registered so it stays low while reset is asserted
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state      <= IDLE;
            wptr       <= '0;
            phase      <= '0;
            tap        <= '0;
            s_ready_q  <= 1'b0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            coef_err_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            s_ready_q  <= (state_nxt == IDLE);
            coef_err_q <= io.coef_we && (state != IDLE);
            tap        <= (state == MAC) ? tap + AW'(1) : '0;
            if (accept) begin
                wptr  <= wptr + AW'(1);
                phase <= (phase == PH_LAST) ? '0 : phase + AW'(1);
            end
            if (state == OUT) begin
                if (!m_valid_q) begin
                    m_valid_q <= 1'b1;
                    m_data_q  <= dout;
                end else if (io.m_ready) begin
                    m_valid_q <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            for (int i = 0; i < NTAPS; i++) begin
                dline[i] <= '0;
                coef[i]  <= '0;
            end
        end else begin
            if (accept) dline[wptr] <= io.s_data;
            if (io.coef_we && state == IDLE) coef[io.coef_addr] <= io.coef_data;
        end
    end

    multirate_mac_dp #(
        .DIN_W  (DIN_W),
        .COEF_W (COEF_W),
        .DOUT_W (DOUT_W),
        .ACC_W  (ACC_W),
        .SHIFT  (SHIFT)
    ) u_dp (
        .clk      (ap_clk),
        .rst_n    (ap_rst_n),
        .vld_p0   (vld_p0),
        .first_p0 (first_p0),
        .x_p0     (dline[raddr]),
        .c_p0     (coef[tap]),
        .dout     (dout)
    );

    assign io.s_ready  = s_ready_q;
    assign io.m_valid  = m_valid_q;
    assign io.m_data   = m_data_q;
    assign io.coef_err = coef_err_q;
    assign io.busy     = (state != IDLE);

endmodule
